encryption_fsm: RTL and testbench
=================================

// Module: encryption_fsm
// PURPOSE
//   Control sequencer for the AES-128 encryption datapath. On start it steps through
//   one initial AddRoundKey round, 9 multi-cycle middle rounds and one final round.
//   It emits per-cycle datapath enables and a round index for the key schedule,
//   then returns to IDLE with a one-cycle done pulse.
//   State type state_e {IDLE, INITIAL_ROUND, MID_ROUND, LAST_ROUND} comes from fsm4_pkg.
// PARAMETERS
//   NUM_MID_ROUNDS     9  middle rounds (AES-128)
//   MID_ROUND_CYCLES   3  cycles spent per middle round
//   LAST_ROUND_CYCLES  2  cycles spent in the final round
// PORTS
//   clk                 in   1  clock; all logic on rising edge
//   reset               in   1  synchronous, active-high reset
//   start               in   1  level request; sampled only in IDLE
//   busy                out  1  high in every non-IDLE state
//   done                out  1  one-cycle pulse on return to IDLE
//   round               out  4  current round index 0..10
//   load_en             out  1  latch plaintext and apply round-0 AddRoundKey
//   sub_bytes_en        out  1  SubBytes strobe
//   shift_rows_en       out  1  ShiftRows strobe
//   mix_columns_en      out  1  MixColumns strobe
//   add_round_key_en    out  1  AddRoundKey strobe; also advances the key schedule
// BEHAVIOUR
// - Internal regs: state (state_e), round_count[3:0], round_cycle_count[1:0].
//   All three are named exactly so, because the benches probe them hierarchically.
// - Reset (sync, any state, including mid-operation):
//   - state=IDLE, round_count=0, round_cycle_count=0.
//   - All outputs are 0, including done.
// - IDLE: start=1 at a rising edge -> INITIAL_ROUND next cycle. Otherwise stay in IDLE.
// - INITIAL_ROUND: exactly 1 cycle, round=0.
//   - load_en=1 and add_round_key_en=1.
//   - Next state MID_ROUND, round_count=1, round_cycle_count=0.
// - MID_ROUND: 3 cycles per round, rounds 1..9, 27 cycles total.
//   - cycle 0: sub_bytes_en.
//   - cycle 1: shift_rows_en.
//   - cycle 2: mix_columns_en and add_round_key_en.
//   - At cycle 2, round_cycle_count wraps to 0 and round_count increments.
//   - At cycle 2 of round 9 -> LAST_ROUND with round_count=10.
// - LAST_ROUND: 2 cycles, round=10, no MixColumns.
//   - cycle 0: sub_bytes_en.
//   - cycle 1: shift_rows_en and add_round_key_en.
//   - After cycle 1 -> IDLE with counters cleared.
// - done is registered: high only in the first IDLE cycle after LAST_ROUND.
// - Latency: start sampled at edge N.
//   - INITIAL_ROUND during N+1.
//   - MID_ROUND during N+2..N+28.
//   - LAST_ROUND during N+29..N+30.
//   - IDLE with done=1 during N+31.
// - start is ignored while busy; no abort input.
// - start still high in the done cycle: a new encryption begins next cycle (back-to-back).
// - Strobes are combinational decodes of state and round_cycle_count, mutually
//   exclusive as listed above; round mirrors round_count.
// - Counters never exceed their range; unreachable states return to IDLE.
// TESTING
// - Reset for 1 edge, start=0 -> state IDLE, busy=0, done=0, round=0, all strobes 0.
// - start=1 before an edge -> INITIAL_ROUND for 1 cycle with load_en=1 and add_round_key_en=1.
// - Next 27 cycles -> MID_ROUND; round steps 1..9 every 3 cycles.
//   Strobe pattern per round: sub, shift, mix+ark.
// - Following 2 cycles -> LAST_ROUND at round=10: sub, then shift+ark; no mix_columns_en.
// - Next cycle -> IDLE with done=1 for exactly 1 cycle.
// - start held high -> INITIAL_ROUND again on the cycle after done.
// - Reset asserted during MID_ROUND round 5 -> IDLE next cycle, counters 0, no done pulse.
// - Toggling start mid-run -> sequence timing unchanged.

Source files
------------

// File: rtl/encryption_fsm_if.sv
// Control bus of the AES-128 encryption sequencer: the start request plus the
// status and per-cycle datapath strobes.
interface encryption_fsm_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] round;
  logic       load_en;
  logic       sub_bytes_en;
  logic       shift_rows_en;
  logic       mix_columns_en;
  logic       add_round_key_en;

  // Requester side: issues start, observes status and strobes.
  modport master (
    output start,
    input  busy, done, round, load_en, sub_bytes_en, shift_rows_en,
           mix_columns_en, add_round_key_en
  );

  // Sequencer side.
  modport slave (
    input  start,
    output busy, done, round, load_en, sub_bytes_en, shift_rows_en,
           mix_columns_en, add_round_key_en
  );
endinterface

// File: rtl/encryption_fsm.sv
// AES-128 encryption control sequencer: one initial AddRoundKey round, nine
// three-cycle middle rounds and a two-cycle final round, then a done pulse.
package fsm4_pkg;
  typedef enum logic [1:0] {IDLE, INITIAL_ROUND, MID_ROUND, LAST_ROUND} state_e;
endpackage

module encryption_fsm
  import fsm4_pkg::*;
#(
  parameter int unsigned NUM_MID_ROUNDS    = 9,
  parameter int unsigned MID_ROUND_CYCLES  = 3,
  parameter int unsigned LAST_ROUND_CYCLES = 2
) (
  input logic              clk,
  input logic              reset,
  encryption_fsm_if.slave  bus
);

  localparam logic [3:0] LastMidRound = 4'(NUM_MID_ROUNDS);
  localparam logic [3:0] FinalRound   = 4'(NUM_MID_ROUNDS + 1);
  localparam logic [1:0] MidLastCycle = 2'(MID_ROUND_CYCLES - 1);
  localparam logic [1:0] EndLastCycle = 2'(LAST_ROUND_CYCLES - 1);

  state_e     state, state_next;
  logic [3:0] round_count, round_count_next;
  logic [1:0] round_cycle_count, round_cycle_next;
  logic       done_pulse, done_next;

  // State, counters and registered done pulse; synchronous reset clears all.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      round_count       <= 4'd0;
      round_cycle_count <= 2'd0;
      done_pulse        <= 1'b0;
    end else begin
      state             <= state_next;
      round_count       <= round_count_next;
      round_cycle_count <= round_cycle_next;
      done_pulse        <= done_next;
    end
  end

  // Next-state and counter sequencing; any out-of-range case falls back to IDLE.
  always_comb begin
    state_next       = state;
    round_count_next = round_count;
    round_cycle_next = round_cycle_count;
    done_next        = 1'b0;
    case (state)
      IDLE: begin
        round_count_next = 4'd0;
        round_cycle_next = 2'd0;
        if (bus.start) state_next = INITIAL_ROUND;
      end
      INITIAL_ROUND: begin
        state_next       = MID_ROUND;
        round_count_next = 4'd1;
        round_cycle_next = 2'd0;
      end
      MID_ROUND: begin
        if (round_cycle_count < MidLastCycle) begin
          round_cycle_next = round_cycle_count + 2'd1;
        end else if (round_cycle_count == MidLastCycle && round_count == LastMidRound) begin
          state_next       = LAST_ROUND;
          round_count_next = FinalRound;
          round_cycle_next = 2'd0;
        end else if (round_cycle_count == MidLastCycle && round_count < LastMidRound) begin
          round_count_next = round_count + 4'd1;
          round_cycle_next = 2'd0;
        end else begin
          state_next       = IDLE;
          round_count_next = 4'd0;
          round_cycle_next = 2'd0;
        end
      end
      LAST_ROUND: begin
        if (round_cycle_count < EndLastCycle) begin
          round_cycle_next = round_cycle_count + 2'd1;
        end else begin
          // Only a legitimate end of the final round raises done.
          done_next        = (round_cycle_count == EndLastCycle);
          state_next       = IDLE;
          round_count_next = 4'd0;
          round_cycle_next = 2'd0;
        end
      end
      default: begin
        state_next       = IDLE;
        round_count_next = 4'd0;
        round_cycle_next = 2'd0;
      end
    endcase
  end

  // Status outputs and mutually exclusive datapath strobes decoded from state/cycle.
  always_comb begin
    bus.busy             = (state != IDLE);
    bus.done             = done_pulse;
    bus.round            = round_count;
    bus.load_en          = 1'b0;
    bus.sub_bytes_en     = 1'b0;
    bus.shift_rows_en    = 1'b0;
    bus.mix_columns_en   = 1'b0;
    bus.add_round_key_en = 1'b0;
    case (state)
      INITIAL_ROUND: begin
        bus.load_en          = 1'b1;
        bus.add_round_key_en = 1'b1;
      end
      MID_ROUND: begin
        case (round_cycle_count)
          2'd0: bus.sub_bytes_en = 1'b1;
          2'd1: bus.shift_rows_en = 1'b1;
          2'd2: begin
            bus.mix_columns_en   = 1'b1;
            bus.add_round_key_en = 1'b1;
          end
          default: ;
        endcase
      end
      LAST_ROUND: begin
        case (round_cycle_count)
          2'd0: bus.sub_bytes_en = 1'b1;
          2'd1: begin
            bus.shift_rows_en    = 1'b1;
            bus.add_round_key_en = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_encryption_fsm.sv
// Bench for encryption_fsm: directed runs plus randomized start/reset traffic,
// checked every cycle against a cycle-offset model of the encryption timeline.
module tb_encryption_fsm;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  // Model: t = cycles since start was accepted (0 = idle), done_e = done expected.
  int   t;
  logic done_e;

  encryption_fsm_if bus ();

  encryption_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {busy, done, round[3:0], load, sub, shift, mix, ark} from the timeline.
  function automatic logic [10:0] expected(input int tt, input logic de);
    logic [10:0] v;
    int r, c;
    v = '0;
    if (tt == 0) begin
      v[9] = de;
    end else if (tt == 1) begin
      v[10] = 1'b1; v[4] = 1'b1; v[0] = 1'b1;
    end else if (tt <= 28) begin
      r = (tt - 2) / 3 + 1;
      c = (tt - 2) % 3;
      v[10] = 1'b1;
      v[8:5] = 4'(r);
      if (c == 0) v[3] = 1'b1;
      else if (c == 1) v[2] = 1'b1;
      else begin v[1] = 1'b1; v[0] = 1'b1; end
    end else begin
      v[10] = 1'b1;
      v[8:5] = 4'd10;
      if (tt == 29) v[3] = 1'b1;
      else begin v[2] = 1'b1; v[0] = 1'b1; end
    end
    return v;
  endfunction

  task automatic model_step(input logic rst, input logic st);
    if (rst) begin
      t = 0; done_e = 1'b0;
    end else if (t == 0) begin
      done_e = 1'b0;
      if (st) t = 1;
    end else if (t == 30) begin
      t = 0; done_e = 1'b1;
    end else begin
      t = t + 1; done_e = 1'b0;
    end
  endtask

  task automatic check(input string tag);
    logic [10:0] obs, exp_v;
    obs = {bus.busy, bus.done, bus.round, bus.load_en, bus.sub_bytes_en,
           bus.shift_rows_en, bus.mix_columns_en, bus.add_round_key_en};
    exp_v = expected(t, done_e);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s t=%0d: observed %b expected %b", tag, t, obs, exp_v);
    end
  endtask

  // Drive inputs on the falling edge, advance model at the rising edge, sample #1 later.
  task automatic cycle(input logic rst, input logic st, input string tag);
    @(negedge clk);
    reset = rst;
    bus.start = st;
    @(posedge clk);
    model_step(rst, st);
    #1;
    check(tag);
  endtask

  task automatic check_idle_regs(input string tag);
    logic [6:0] obs;
    obs = {dut.state, dut.round_count, dut.round_cycle_count == 2'd0};
    n_tests++;
    assert (obs === {fsm4_pkg::IDLE, 4'd0, 1'b1}) else begin
      n_fail++;
      $error("FAIL %s: observed state/round_count/cyc0 %b expected %b", tag, obs,
             {fsm4_pkg::IDLE, 4'd0, 1'b1});
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    t = 0;
    done_e = 1'b0;
    reset = 1'b1;
    bus.start = 1'b0;

    // Reset state.
    cycle(1'b1, 1'b0, "reset");
    check_idle_regs("reset_regs");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, "idle");

    // Single encryption from a one-cycle start pulse.
    cycle(1'b0, 1'b1, "start_pulse");
    for (int i = 0; i < 35; i++) cycle(1'b0, 1'b0, "single_run");

    // Start held high: back-to-back encryptions.
    for (int i = 0; i < 70; i++) cycle(1'b0, 1'b1, "back_to_back");
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, "drain");

    // Reset during middle round 5: IDLE next cycle, no done afterwards.
    cycle(1'b0, 1'b1, "start_for_abort");
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, "to_round5");
    cycle(1'b1, 1'b0, "reset_mid_round5");
    check_idle_regs("reset_mid_regs");
    for (int i = 0; i < 35; i++) cycle(1'b0, 1'b0, "after_abort");

    // Toggling start mid-run must not disturb the timeline.
    cycle(1'b0, 1'b1, "start_toggle_run");
    for (int i = 0; i < 34; i++) cycle(1'b0, logic'(i % 2), "toggle_start");

    // Randomized start and occasional reset.
    for (int i = 0; i < 600; i++) begin
      logic r, s;
      r = ($urandom_range(0, 79) == 0);
      s = ($urandom_range(0, 3) == 0);
      cycle(r, s, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
